pacman_death_ctrl: RTL and testbench
====================================

Name: pacman_death_ctrl

Overview:
- Downstream consumer of the Pac-Man movement block. Takes Pac-Man's BallX/BallY each frame and compares them with the four ghost positions.
- Produces the Kill freeze signal that the movement block consumes, plus a one-frame Respawn pulse, the lives count, a death-animation frame index and Game_Over.
- Runs one evaluation per frame_clk (vsync-rate) edge.

Parameters:
- HIT_DIST, 6: hit when both |dX| and |dY| are strictly less than this (pixels).
- DEATH_FRAMES, 120: frames spent in DYING, including the entry frame.
- GRACE_FRAMES, 60: frames after respawn during which all hits are ignored.
- START_LIVES, 3: lives loaded at reset (1..3).

Ports:
- Reset, in, 1: asynchronous, active-high.
- frame_clk, in, 1: clock, one edge per video frame.
- BallX, in, 10: Pac-Man centre X.
- BallY, in, 10: Pac-Man centre Y.
- GhostX, in, 40: ghost i centre X in bits [10i+9:10i], i = 0..3.
- GhostY, in, 40: ghost i centre Y, same packing.
- Ghost_Frightened, in, 4: bit i high means ghost i is edible.
- Kill, out, 1: freeze Pac-Man movement.
- Respawn, out, 1: one-frame pulse; the movement/ghost blocks return to their start positions.
- Ghost_Eaten, out, 4: one-frame pulse per ghost eaten.
- Lives, out, 2: remaining lives.
- Death_Anim_Frame, out, 3: sprite index for the death animation.
- Game_Over, out, 1: sticky until Reset.

Behaviour:
- Reset (async) values:
  - state = GRACE, grace counter = GRACE_FRAMES-1.
  - Lives = START_LIVES.
  - Kill = 0, Respawn = 0, Ghost_Eaten = 0, Death_Anim_Frame = 0, Game_Over = 0.
- All outputs are registered. A hit seen on edge N is reflected on the outputs after edge N.
- Distance arithmetic:
  - |a-b| is unsigned, 10-bit, computed as larger minus smaller. No wrap.
  - hit_i = (|BallX-GhostX_i| < HIT_DIST) && (|BallY-GhostY_i| < HIT_DIST).
  - lethal = OR over i of (hit_i && !Ghost_Frightened[i]).
  - edible_i = hit_i && Ghost_Frightened[i].
- States:
  - ALIVE:
    - Kill = 0.
    - If lethal: go to DYING, Kill = 1, death counter = DEATH_FRAMES-1, anim subcounter = 0, Death_Anim_Frame = 0, Ghost_Eaten = 0 (death wins over eating in the same frame).
    - Else: Ghost_Eaten = edible_i vector, which clears the next frame unless still hit. A ghost still overlapping while frightened pulses again; the ghost block is responsible for relocating an eaten ghost.
  - DYING:
    - Kill = 1, hits ignored, death counter decrements each frame.
    - 4-bit subcounter increments; on wrap 15→0, Death_Anim_Frame increments, saturating at 7.
    - When the counter reaches 0 with Lives == 1: Lives = 0, go to GAME_OVER.
    - When the counter reaches 0 with Lives > 1: Lives decrements, go to RESPAWN.
  - RESPAWN:
    - Lasts exactly one frame: Respawn = 1, Kill = 1, Death_Anim_Frame = 0.
    - Next: GRACE, grace counter = GRACE_FRAMES-1.
  - GRACE:
    - Respawn = 0, Kill = 0, hits and eats ignored (Ghost_Eaten = 0).
    - Counter decrements; at 0 go to ALIVE.
  - GAME_OVER:
    - Kill = 1, Game_Over = 1, Death_Anim_Frame held at 7.
    - Absorbing; only Reset leaves it.
- Reset while in DYING, RESPAWN or GAME_OVER returns immediately to the reset state, with Lives reloaded.
- Lives never underflows; the decrement happens only in the DYING→RESPAWN transition.

Optional Feature:
- Macro: PACMAN_EXTRA_LIFE_EN.
- When defined, add input Score_Milestone (1 bit, one-frame pulse from the score block):
  - The first pulse after Reset sets Lives = min(Lives+1, 3) on the next edge.
  - Later pulses are ignored (one-shot flag cleared only by Reset).
  - A pulse in DYING applies before that frame's end-of-dying decrement; the increment and decrement on the same edge net to Lives unchanged, then RESPAWN.
  - Pulses in GAME_OVER are ignored.
- When undefined, the port does not exist and Lives only ever decreases from START_LIVES.

Test Plan:
- Reset, hold Ball=(320,274) and all ghosts at (0,0) for 70 frames -> Kill = 0 throughout, state reaches ALIVE after 60 frames, Lives = 3.
- After grace, Ghost1 at (324,270), not frightened -> Kill = 1 on next edge, Death_Anim_Frame steps 0..7 every 16 frames, then saturates. At frame 120 Respawn pulses for exactly one frame, Lives = 2, Kill = 0 the following frame.
- Ghost2 at (326,274), which is exactly HIT_DIST away -> no hit. Move it to (325,274) -> Kill asserts.
- Ghost0 frightened and Ghost3 non-frightened both overlapping in the same frame -> Kill = 1, Ghost_Eaten = 0000. Ghost0 frightened alone -> Ghost_Eaten = 0001 for one frame.
- Three lethal deaths from reset -> after the third DYING, Lives = 0, Game_Over = 1, Kill = 1, Respawn never pulses. Further hits cause no change. Reset restores Lives = 3 and Game_Over = 0.
- With PACMAN_EXTRA_LIFE_EN: at Lives = 2, Score_Milestone pulses -> Lives = 3. A second pulse after a death -> Lives unchanged.

Source files
------------

// File: rtl/pacman_death_ctrl.sv
// Pac-Man death controller: ghost collision detection, death animation, lives, respawn and game over.
// Optional macro PACMAN_EXTRA_LIFE_EN adds the Score_Milestone one-shot extra-life input.
module pacman_death_ctrl #(
  parameter int HIT_DIST     = 6,
  parameter int DEATH_FRAMES = 120,
  parameter int GRACE_FRAMES = 60,
  parameter int START_LIVES  = 3
) (
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [9:0]  BallX,
  input  logic [9:0]  BallY,
  input  logic [39:0] GhostX,
  input  logic [39:0] GhostY,
  input  logic [3:0]  Ghost_Frightened,
`ifdef PACMAN_EXTRA_LIFE_EN
  input  logic        Score_Milestone,
`endif
  output logic        Kill,
  output logic        Respawn,
  output logic [3:0]  Ghost_Eaten,
  output logic [1:0]  Lives,
  output logic [2:0]  Death_Anim_Frame,
  output logic        Game_Over
);

  localparam int CNT_W = (DEATH_FRAMES > GRACE_FRAMES) ? $clog2(DEATH_FRAMES) : $clog2(GRACE_FRAMES);
  localparam logic [CNT_W-1:0] DEATH_INIT = CNT_W'(DEATH_FRAMES - 1);
  localparam logic [CNT_W-1:0] GRACE_INIT = CNT_W'(GRACE_FRAMES - 1);
  localparam logic [9:0]       HIT_LIM    = 10'(HIT_DIST);
  localparam logic [1:0]       LIVES_INIT = 2'(START_LIVES);

  typedef enum logic [2:0] {ALIVE, DYING, RESPAWN, GRACE, GAME_OVER} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic [3:0]       anim_sub, anim_sub_next;
  logic [2:0]       anim_next;
  logic [1:0]       lives_base, lives_next;
  logic             kill_next, respawn_next, game_over_next;
  logic [3:0]       eaten_next;
  logic [3:0]       hit, edible;
  logic             lethal;

  // Unsigned distance without wrap: larger minus smaller.
  function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  always_comb begin
    hit    = '0;
    edible = '0;
    lethal = 1'b0;
    for (int i = 0; i < 4; i++) begin
      hit[i]    = (abs_diff(BallX, GhostX[10*i +: 10]) < HIT_LIM) &&
                  (abs_diff(BallY, GhostY[10*i +: 10]) < HIT_LIM);
      edible[i] = hit[i] && Ghost_Frightened[i];
      lethal    = lethal || (hit[i] && !Ghost_Frightened[i]);
    end
  end

`ifdef PACMAN_EXTRA_LIFE_EN
  // The bonus lands before any end-of-dying decrement on the same edge.
  logic extra_used, bonus;
  assign bonus = Score_Milestone && !extra_used && (state != GAME_OVER);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset)      extra_used <= 1'b0;
    else if (bonus) extra_used <= 1'b1;
  end

  always_comb begin
    lives_base = Lives;
    if (bonus) lives_base = (Lives == 2'd3) ? 2'd3 : Lives + 2'd1;
  end
`else
  always_comb begin
    lives_base = Lives;
  end
`endif

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state            <= GRACE;
      count            <= GRACE_INIT;
      anim_sub         <= 4'd0;
      Lives            <= LIVES_INIT;
      Kill             <= 1'b0;
      Respawn          <= 1'b0;
      Ghost_Eaten      <= 4'd0;
      Death_Anim_Frame <= 3'd0;
      Game_Over        <= 1'b0;
    end else begin
      state            <= state_next;
      count            <= count_next;
      anim_sub         <= anim_sub_next;
      Lives            <= lives_next;
      Kill             <= kill_next;
      Respawn          <= respawn_next;
      Ghost_Eaten      <= eaten_next;
      Death_Anim_Frame <= anim_next;
      Game_Over        <= game_over_next;
    end
  end

  always_comb begin
    state_next     = state;
    count_next     = count;
    anim_sub_next  = anim_sub;
    anim_next      = Death_Anim_Frame;
    lives_next     = lives_base;
    kill_next      = Kill;
    respawn_next   = 1'b0;
    eaten_next     = 4'd0;
    game_over_next = Game_Over;

    case (state)
      ALIVE: begin
        kill_next = 1'b0;
        if (lethal) begin
          state_next    = DYING;
          kill_next     = 1'b1;
          count_next    = DEATH_INIT;
          anim_sub_next = 4'd0;
          anim_next     = 3'd0;
        end else begin
          eaten_next = edible;
        end
      end

      DYING: begin
        kill_next = 1'b1;
        if (count == '0) begin
          if (lives_base <= 2'd1) begin
            lives_next     = 2'd0;
            state_next     = GAME_OVER;
            game_over_next = 1'b1;
            anim_next      = 3'd7;
          end else begin
            lives_next   = lives_base - 2'd1;
            state_next   = RESPAWN;
            respawn_next = 1'b1;
            anim_next    = 3'd0;
          end
        end else begin
          count_next    = count - 1'b1;
          anim_sub_next = anim_sub + 4'd1;
          if (anim_sub == 4'd15 && Death_Anim_Frame != 3'd7)
            anim_next = Death_Anim_Frame + 3'd1;
        end
      end

      RESPAWN: begin
        kill_next  = 1'b0;
        state_next = GRACE;
        count_next = GRACE_INIT;
      end

      GRACE: begin
        kill_next = 1'b0;
        if (count == '0) state_next = ALIVE;
        else             count_next = count - 1'b1;
      end

      GAME_OVER: begin
        kill_next      = 1'b1;
        game_over_next = 1'b1;
        anim_next      = 3'd7;
      end

      default: begin
        state_next = GRACE;
        count_next = GRACE_INIT;
      end
    endcase
  end

endmodule

// File: tb/tb_pacman_death_ctrl.sv
// Self-checking bench for pacman_death_ctrl: directed scenarios then random play against a frame-timeline model.
module tb_pacman_death_ctrl;

  localparam int HIT_DIST     = 6;
  localparam int DEATH_FRAMES = 120;
  localparam int GRACE_FRAMES = 60;
  localparam int START_LIVES  = 3;

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic [9:0]  BallX, BallY;
  logic [39:0] GhostX, GhostY;
  logic [3:0]  Ghost_Frightened;
  logic        Kill, Respawn, Game_Over;
  logic [3:0]  Ghost_Eaten;
  logic [1:0]  Lives;
  logic [2:0]  Death_Anim_Frame;
  logic        milestone;

  pacman_death_ctrl #(
    .HIT_DIST(HIT_DIST), .DEATH_FRAMES(DEATH_FRAMES),
    .GRACE_FRAMES(GRACE_FRAMES), .START_LIVES(START_LIVES)
  ) dut (
    .Reset(Reset),
    .frame_clk(frame_clk),
    .BallX(BallX),
    .BallY(BallY),
    .GhostX(GhostX),
    .GhostY(GhostY),
    .Ghost_Frightened(Ghost_Frightened),
`ifdef PACMAN_EXTRA_LIFE_EN
    .Score_Milestone(milestone),
`endif
    .Kill(Kill),
    .Respawn(Respawn),
    .Ghost_Eaten(Ghost_Eaten),
    .Lives(Lives),
    .Death_Anim_Frame(Death_Anim_Frame),
    .Game_Over(Game_Over)
  );

  always #5 frame_clk = ~frame_clk;

  // Model: frame index since reset, plus the frame of the last death and last respawn.
  int       t, last_respawn, death_at;
  bit       m_dying, m_over, m_used;
  int       m_lives, m_anim;
  bit       m_kill, m_respawn;
  logic [3:0] m_eaten;
  int       n_checks = 0, n_fail = 0, respawn_seen = 0;

  task automatic modelReset();
    t = 0; last_respawn = -1; death_at = 0;
    m_dying = 0; m_over = 0; m_used = 0;
    m_lives = START_LIVES; m_anim = 0;
    m_kill = 0; m_respawn = 0; m_eaten = 4'd0;
  endtask

  function automatic bit isHit(int i);
    int dx, dy;
    dx = int'(BallX) - int'(GhostX[10*i +: 10]);
    dy = int'(BallY) - int'(GhostY[10*i +: 10]);
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    return (dx < HIT_DIST) && (dy < HIT_DIST);
  endfunction

  task automatic modelEdge(input bit pulse);
    bit lethal = 0;
    logic [3:0] edible = 4'd0;
    int k;
    t++;
    for (int i = 0; i < 4; i++)
      if (isHit(i)) begin
        if (Ghost_Frightened[i]) edible[i] = 1'b1;
        else lethal = 1;
      end
    m_respawn = 0;
    m_eaten   = 4'd0;
    if (m_over) return;
`ifdef PACMAN_EXTRA_LIFE_EN
    if (pulse && !m_used) begin
      m_used = 1;
      if (m_lives < 3) m_lives++;
    end
`endif
    if (m_dying) begin
      k = t - death_at;
      if (k < DEATH_FRAMES) begin
        m_kill = 1;
        m_anim = (k / 16 > 7) ? 7 : k / 16;
      end else begin
        m_dying = 0;
        if (m_lives == 1) begin
          m_lives = 0; m_over = 1; m_kill = 1; m_anim = 7;
        end else begin
          m_lives--; m_respawn = 1; m_kill = 1; m_anim = 0; last_respawn = t;
        end
      end
    end else if (t > last_respawn + GRACE_FRAMES + 1) begin
      if (lethal) begin
        m_dying = 1; death_at = t; m_kill = 1; m_anim = 0;
      end else begin
        m_kill = 0; m_eaten = edible;
      end
    end else begin
      m_kill = 0;
    end
  endtask

  task automatic compare(input string name, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (frame %0d)", name, obs, exp, t);
    end
  endtask

  task automatic checkOutput();
    if (Respawn === 1'b1) respawn_seen++;
    compare("Kill",       8'(Kill),             8'(m_kill));
    compare("Respawn",    8'(Respawn),          8'(m_respawn));
    compare("Ghost_Eaten",8'(Ghost_Eaten),      8'(m_eaten));
    compare("Lives",      8'(Lives),            8'(m_lives));
    compare("Anim",       8'(Death_Anim_Frame), 8'(m_anim));
    compare("Game_Over",  8'(Game_Over),        8'(m_over));
  endtask

  task automatic applyStimulus(input int bx, input int by, input logic [3:0] fr);
    BallX = 10'(bx); BallY = 10'(by); Ghost_Frightened = fr;
  endtask

  task automatic setGhost(input int i, input int x, input int y);
    GhostX[10*i +: 10] = 10'(x);
    GhostY[10*i +: 10] = 10'(y);
  endtask

  task automatic frame(input bit pulse);
    milestone = pulse;
    @(posedge frame_clk);
    modelEdge(pulse);
    #1;
    checkOutput();
    milestone = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame(1'b0);
  endtask

  task automatic doReset();
    Reset = 1'b1;
    modelReset();
    #2;
    compare("reset_Lives", 8'(Lives), 8'(START_LIVES));
    compare("reset_Kill",  8'(Kill),  8'd0);
    compare("reset_GO",    8'(Game_Over), 8'd0);
    compare("reset_Anim",  8'(Death_Anim_Frame), 8'd0);
    @(posedge frame_clk);
    #1;
    Reset = 1'b0;
  endtask

  function automatic int clampPix(int v);
    return (v < 0) ? 0 : (v > 1023) ? 1023 : v;
  endfunction

  initial begin
    int mark, bx, by;
    Reset = 1'b0; milestone = 1'b0;
    GhostX = '0; GhostY = '0;
    applyStimulus(320, 274, 4'b0000);
    #1;
    doReset();

    // Grace then alive, no ghosts near.
    frames(70);
    compare("alive_Kill",  8'(Kill),  8'd0);
    compare("alive_Lives", 8'(Lives), 8'd3);

    // First lethal hit, full death animation, single respawn pulse.
    setGhost(1, 324, 270);
    frame(1'b0);
    compare("hit_Kill", 8'(Kill), 8'd1);
    setGhost(1, 0, 0);
    mark = respawn_seen;
    frames(130);
    compare("respawn_count", 8'(respawn_seen - mark), 8'd1);
    compare("death1_Lives",  8'(Lives), 8'd2);
    compare("death1_Kill",   8'(Kill),  8'd0);
    frames(55);

    // Exactly HIT_DIST away is no hit; one pixel closer is.
    setGhost(2, 326, 274);
    frame(1'b0);
    compare("edge_nohit", 8'(Kill), 8'd0);
    setGhost(2, 325, 274);
    frame(1'b0);
    compare("edge_hit", 8'(Kill), 8'd1);
    setGhost(2, 0, 0);
    frames(185);
    compare("death2_Lives", 8'(Lives), 8'd1);

    // Eating a frightened ghost alone, then eat + lethal in the same frame.
    applyStimulus(320, 274, 4'b0001);
    setGhost(0, 322, 276);
    frame(1'b0);
    compare("eat_pulse", 8'(Ghost_Eaten), 8'b0001);
    setGhost(0, 0, 0);
    frame(1'b0);
    compare("eat_clear", 8'(Ghost_Eaten), 8'b0000);
    setGhost(0, 322, 276);
    setGhost(3, 318, 272);
    frame(1'b0);
    compare("mixed_Kill",  8'(Kill), 8'd1);
    compare("mixed_Eaten", 8'(Ghost_Eaten), 8'd0);
    setGhost(0, 0, 0);
    setGhost(3, 0, 0);
    mark = respawn_seen;
    frames(125);
    compare("over_GO",      8'(Game_Over), 8'd1);
    compare("over_Lives",   8'(Lives), 8'd0);
    compare("over_Kill",    8'(Kill), 8'd1);
    compare("over_Anim",    8'(Death_Anim_Frame), 8'd7);
    compare("over_respawn", 8'(respawn_seen - mark), 8'd0);
    setGhost(3, 320, 274);
    frames(5);
    setGhost(3, 0, 0);
    doReset();
    compare("rst_GO", 8'(Game_Over), 8'd0);

    // Distances must not wrap around the 10-bit range.
    frames(62);
    applyStimulus(1, 274, 4'b0000);
    setGhost(0, 1022, 274);
    frame(1'b0);
    compare("wrap_lo", 8'(Kill), 8'd0);
    applyStimulus(1020, 274, 4'b0000);
    setGhost(0, 2, 274);
    frame(1'b0);
    compare("wrap_hi", 8'(Kill), 8'd0);
    setGhost(0, 0, 0);

    // Random play.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 399) == 0) doReset();
      if ($urandom_range(0, 3) == 0) begin
        bx = int'($urandom_range(0, 1023));
        by = int'($urandom_range(0, 1023));
        applyStimulus(bx, by, 4'($urandom_range(0, 15)));
        for (int g = 0; g < 4; g++) begin
          if ($urandom_range(0, 7) == 0)
            setGhost(g, clampPix(bx + int'($urandom_range(0, 14)) - 7),
                        clampPix(by + int'($urandom_range(0, 14)) - 7));
          else
            setGhost(g, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
        end
      end
      frame($urandom_range(0, 49) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
